// File: rtl/ps2_kbd_event_ctrl.sv
// PS/2 keyboard event controller: pops scan-code bytes from the receiver FIFO, folds E0/F0
// prefixes into key events and queues them for an APB reader. Define PS2_EVT_IRQ_EN for irq.
module ps2_kbd_event_ctrl #(
  parameter int EVQ_DEPTH = 8,
  parameter int EVQ_AW    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_ready,
  output logic        kbd_nextdata_n
`ifdef PS2_EVT_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [7:0]        CODE_EXT   = 8'hE0;
  localparam logic [7:0]        CODE_BRK   = 8'hF0;
  localparam logic [EVQ_AW:0]   FULL_COUNT = (EVQ_AW + 1)'(EVQ_DEPTH);
  localparam logic [EVQ_AW:0]   CNT_ONE    = 1;
  localparam logic [EVQ_AW-1:0] PTR_ONE    = 1;

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              dropped_q, dropped_d;
  logic [EVQ_AW-1:0] wptr_q, wptr_d;
  logic [EVQ_AW-1:0] rptr_q, rptr_d;
  logic [EVQ_AW:0]   count_q, count_d;

  logic [9:0]        evq_mem [EVQ_DEPTH];

  logic              access;
  logic [1:0]        reg_sel;
  logic              acc_err;
  logic              q_empty;
  logic              q_full;
  logic              ev_pop;
  logic              ctrl_wr;
  logic              flush;
  logic              push_req;
  logic              push_en;
  logic              unused_ok;

  assign access   = in_psel & in_penable;
  assign reg_sel  = in_paddr[3:2];
  assign acc_err  = access & ((reg_sel == 2'd3) | (in_pwrite & (reg_sel != 2'd2)));
  assign q_empty  = (count_q == '0);
  assign q_full   = (count_q == FULL_COUNT);
  assign ev_pop   = access & ~in_pwrite & (reg_sel == 2'd0) & ~q_empty;
  assign ctrl_wr  = access & in_pwrite & (reg_sel == 2'd2);
  assign flush    = ctrl_wr & in_pwdata[1];
  assign push_req = (state_q == ST_SETTLE) & (byte_q != CODE_EXT) & (byte_q != CODE_BRK);
  // A flush in the same cycle as a parsed code discards that code.
  assign push_en  = push_req & ~flush;

  assign unused_ok = ^{in_paddr[31:4], in_paddr[1:0], in_pwdata[31:2]};

  assign in_pready      = access;
  assign in_pslverr     = acc_err;
  assign kbd_nextdata_n = (state_q != ST_POP);

  always_comb begin
    in_prdata = 32'd0;
    case (reg_sel)
      2'd0: in_prdata = q_empty ? 32'd0 : {1'b1, 21'd0, evq_mem[rptr_q]};
      2'd1: in_prdata = {16'd0, 8'(count_q), 6'd0, dropped_q, ~q_empty};
      2'd2: in_prdata = {29'd0, irq_en_q, 1'b0, enable_q};
      default: in_prdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    dropped_d = dropped_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // Entering POP only with a free slot reserves it for the coming push.
        if (enable_q && kbd_ready && !q_full) begin
          state_d = ST_POP;
          byte_d  = kbd_data;
        end
      end
      ST_POP: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
        if (byte_q == CODE_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == CODE_BRK) begin
          brk_d = 1'b1;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ctrl_wr) begin
      enable_d = in_pwdata[0];
`ifdef PS2_EVT_IRQ_EN
      irq_en_d = in_pwdata[2];
`endif
    end

    if (flush) begin
      ext_d     = 1'b0;
      brk_d     = 1'b0;
      dropped_d = push_req;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
    end else begin
      if (push_en) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (ev_pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      unique case ({push_en, ev_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      byte_q    <= 8'd0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      enable_q  <= 1'b1;
      irq_en_q  <= 1'b0;
      dropped_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      enable_q  <= enable_d;
      irq_en_q  <= irq_en_d;
      dropped_q <= dropped_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Event storage carries no reset; entries are only read when count says valid.
  always_ff @(posedge clock) begin
    if (push_en) begin
      evq_mem[wptr_q] <= {brk_q, ext_q, byte_q};
    end
  end

`ifdef PS2_EVT_IRQ_EN
  logic irq_q, irq_d;

  // Built from next-state values so irq tracks the registered count exactly.
  assign irq_d = irq_en_d & (count_d != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
